// File: rtl/decode_stage_pipelined.sv
// LEGv8 decode stage: parse, control, regfile with WB bypass, sign-extend, registered ID/EX.
// Latency 1 cycle; a load-use hazard raises id_stall and inserts a bubble, and flush overrides the stall.
module decode_stage_pipelined #(
    parameter int WORD     = 64,
    parameter int NUM_REGS = 32,
    parameter int ZERO_REG = 31,
    parameter int LINK_REG = 30
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_valid,
    input  logic [31:0]     instruction,
    input  logic [WORD-1:0] if_pc,
    input  logic            flush,
    input  logic            wb_reg_write,
    input  logic [4:0]      wb_write_reg,
    input  logic [WORD-1:0] wb_write_data,
    output logic            id_stall,
    output logic            ex_valid,
    output logic [WORD-1:0] ex_pc,
    output logic [10:0]     ex_opcode,
    output logic [WORD-1:0] ex_read_data1,
    output logic [WORD-1:0] ex_read_data2,
    output logic [WORD-1:0] ex_imm,
    output logic [4:0]      ex_rn,
    output logic [4:0]      ex_rm,
    output logic [4:0]      ex_write_reg,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_alu_src,
    output logic            ex_reg_write,
    output logic            ex_update_sreg,
    output logic [2:0]      ex_branch_op,
    output logic [1:0]      ex_alu_op,
    output logic [1:0]      ex_mem_to_reg
);
    localparam int AW = ($clog2(NUM_REGS) < 5) ? 5 : $clog2(NUM_REGS);
    localparam logic [4:0] ZR = 5'(ZERO_REG);
    localparam logic [4:0] LR = 5'(LINK_REG);
    localparam logic [2:0] IMM_I = 3'd0, IMM_D = 3'd1, IMM_B = 3'd2, IMM_CB = 3'd3, IMM_SH = 3'd4;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic       update_sreg;
        logic [2:0] branch_op;
        logic [1:0] alu_op;
        logic [1:0] mem_to_reg;
    } ctrl_t;

    logic [10:0]     w_opcode;
    logic [4:0]      w_rm, w_rn, w_rd, w_read_reg2, w_write_reg;
    ctrl_t           w_ctrl;
    logic            w_reg2loc, w_wr_src, w_uses_r2;
    logic [2:0]      w_imm_kind;
    logic [WORD-1:0] w_imm;
    logic [4:0]      w_ridx [2];
    logic [WORD-1:0] w_rdat [2];
    logic            w_hazard;

    logic [WORD-1:0] r_regs [NUM_REGS];
    logic            r_valid;
    ctrl_t           r_ctrl;
    logic [WORD-1:0] r_pc, r_rd1, r_rd2, r_imm;
    logic [10:0]     r_opcode;
    logic [4:0]      r_rn, r_rm, r_wr;

    assign w_opcode    = instruction[31:21];
    assign w_rm        = instruction[20:16];
    assign w_rn        = instruction[9:5];
    assign w_rd        = instruction[4:0];
    assign w_read_reg2 = w_reg2loc ? w_rd : w_rm;
    assign w_write_reg = w_wr_src ? LR : w_rd;

    always_comb begin
        w_ctrl     = '0;
        w_reg2loc  = 1'b0;
        w_wr_src   = 1'b0;
        w_uses_r2  = 1'b0;
        w_imm_kind = IMM_I;
        casez (w_opcode)
            11'b10001011000, 11'b11001011000, 11'b10001010000,
            11'b10101010000, 11'b11001010000: begin
                w_ctrl.reg_write = 1'b1; w_ctrl.alu_op = 2'b10; w_uses_r2 = 1'b1;
            end
            11'b10101011000, 11'b11101011000: begin
                w_ctrl.reg_write = 1'b1; w_ctrl.alu_op = 2'b10; w_uses_r2 = 1'b1;
                w_ctrl.update_sreg = 1'b1;
            end
            11'b11010011011, 11'b11010011010: begin
                w_ctrl.reg_write = 1'b1; w_ctrl.alu_op = 2'b10; w_uses_r2 = 1'b1;
                w_imm_kind = IMM_SH;
            end
            11'b1001000100?, 11'b1101000100?: begin
                w_ctrl.reg_write = 1'b1; w_ctrl.alu_op = 2'b10; w_ctrl.alu_src = 1'b1;
            end
            11'b1011000100?, 11'b1111000100?: begin
                w_ctrl.reg_write = 1'b1; w_ctrl.alu_op = 2'b10; w_ctrl.alu_src = 1'b1;
                w_ctrl.update_sreg = 1'b1;
            end
            11'b11111000010: begin
                w_ctrl.mem_read = 1'b1; w_ctrl.reg_write = 1'b1; w_ctrl.alu_src = 1'b1;
                w_ctrl.mem_to_reg = 2'b01; w_imm_kind = IMM_D;
            end
            11'b11111000000: begin
                w_ctrl.mem_write = 1'b1; w_ctrl.alu_src = 1'b1; w_reg2loc = 1'b1;
                w_uses_r2 = 1'b1; w_imm_kind = IMM_D;
            end
            11'b000101?????: begin
                w_ctrl.branch_op = 3'b001; w_imm_kind = IMM_B;
            end
            // BL writes the return address (PC+4) into the link register
            11'b100101?????: begin
                w_ctrl.branch_op = 3'b100; w_ctrl.reg_write = 1'b1; w_ctrl.mem_to_reg = 2'b10;
                w_wr_src = 1'b1; w_imm_kind = IMM_B;
            end
            11'b10110100???, 11'b10110101???: begin
                w_ctrl.branch_op = w_opcode[3] ? 3'b011 : 3'b010; w_ctrl.alu_op = 2'b01;
                w_reg2loc = 1'b1; w_uses_r2 = 1'b1; w_imm_kind = IMM_CB;
            end
            11'b01010100???: begin
                w_ctrl.branch_op = 3'b101; w_imm_kind = IMM_CB;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (w_imm_kind)
            IMM_D:   w_imm = {{(WORD-9){instruction[20]}}, instruction[20:12]};
            IMM_B:   w_imm = {{(WORD-26){instruction[25]}}, instruction[25:0]};
            IMM_CB:  w_imm = {{(WORD-19){instruction[23]}}, instruction[23:5]};
            IMM_SH:  w_imm = {{(WORD-6){1'b0}}, instruction[15:10]};
            default: w_imm = {{(WORD-12){1'b0}}, instruction[21:10]};
        endcase
    end

    assign w_ridx[0] = w_rn;
    assign w_ridx[1] = w_read_reg2;

    for (genvar p = 0; p < 2; p++) begin : g_rd
        always_comb begin
            w_rdat[p] = '0;
            if (w_ridx[p] == ZR || int'({27'd0, w_ridx[p]}) >= NUM_REGS)
                w_rdat[p] = '0;
            else if (wb_reg_write && wb_write_reg == w_ridx[p])
                w_rdat[p] = wb_write_data;
            else
                w_rdat[p] = r_regs[AW'(w_ridx[p])];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (wb_reg_write && wb_write_reg != ZR && int'({27'd0, wb_write_reg}) < NUM_REGS) begin
            r_regs[AW'(wb_write_reg)] <= wb_write_data;
        end
    end

    // rn is compared unconditionally; read_reg2 only when the opcode actually reads it
    assign w_hazard = if_valid && r_valid && r_ctrl.mem_read && r_wr != ZR &&
                      (w_rn == r_wr || (w_uses_r2 && w_read_reg2 == r_wr));
    assign id_stall = w_hazard && !flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid  <= 1'b0;
            r_ctrl   <= '0;
            r_pc     <= '0;
            r_opcode <= '0;
            r_rd1    <= '0;
            r_rd2    <= '0;
            r_imm    <= '0;
            r_rn     <= '0;
            r_rm     <= '0;
            r_wr     <= '0;
        end else if (flush || w_hazard) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else begin
            r_valid  <= if_valid;
            r_ctrl   <= if_valid ? w_ctrl : '0;
            r_pc     <= if_pc;
            r_opcode <= w_opcode;
            r_rd1    <= w_rdat[0];
            r_rd2    <= w_rdat[1];
            r_imm    <= w_imm;
            r_rn     <= w_rn;
            r_rm     <= w_read_reg2;
            r_wr     <= w_write_reg;
        end
    end

    assign ex_valid       = r_valid;
    assign ex_pc          = r_pc;
    assign ex_opcode      = r_opcode;
    assign ex_read_data1  = r_rd1;
    assign ex_read_data2  = r_rd2;
    assign ex_imm         = r_imm;
    assign ex_rn          = r_rn;
    assign ex_rm          = r_rm;
    assign ex_write_reg   = r_wr;
    assign ex_mem_read    = r_ctrl.mem_read;
    assign ex_mem_write   = r_ctrl.mem_write;
    assign ex_alu_src     = r_ctrl.alu_src;
    assign ex_reg_write   = r_ctrl.reg_write;
    assign ex_update_sreg = r_ctrl.update_sreg;
    assign ex_branch_op   = r_ctrl.branch_op;
    assign ex_alu_op      = r_ctrl.alu_op;
    assign ex_mem_to_reg  = r_ctrl.mem_to_reg;
endmodule
